dbus_arbiter: RTL
=================

# dbus_arbiter

Shares the single SRAM-like data bus between the pipeline memory requester (PREMEM/MEM load-store path) and the uncached store buffer drain. Grants one requester per bus request and tracks up to OUTSTANDING in-flight transactions in order, so each `data_data_ok` is routed back to its owner. On a pipeline flush, responses for killed pipeline transactions are absorbed silently. It sits between the MEM-side requesters and the data bus bridge.

## Interface
- OUTSTANDING, default 2: maximum in-flight bus transactions; power of 2, at least 2.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- pipe_req / pipe_wr  in  1 / 1  pipeline request and write flag
- pipe_size  in  2  0=byte, 1=half, 2=word
- pipe_addr / pipe_wdata  in  32 / 32  pipeline address and write data
- pipe_wstrb  in  4  pipeline byte enables
- pipe_addr_ok / pipe_data_ok  out  1 / 1  pipeline accepted / pipeline response
- pipe_rdata  out  32  read data for the pipeline
- sb_req  in  1  store-buffer drain request (write only)
- sb_size, sb_addr, sb_wstrb, sb_wdata  in  2, 32, 4, 32  store-buffer payload
- sb_addr_ok / sb_data_ok  out  1 / 1  store-buffer accepted / write done
- flush  in  1  kills every pipeline transaction that is in flight or latched
- data_req, data_wr  out  1, 1  bus request and write flag
- data_size, data_addr, data_wstrb, data_wdata  out  2, 32, 4, 32  bus payload
- data_addr_ok, data_data_ok  in  1, 1  bus accept and response
- data_rdata  in  32  bus read data
- busy  out  1  any transaction latched or in flight

## Operation
- Grant FSM has two states, IDLE and HOLD.
- **IDLE**
  - Arbitration is combinational with fixed priority: sb over pipe. Giving the store buffer priority guarantees older uncached stores reach the bus before younger loads.
  - The winner's payload drives the bus directly.
  - If `data_addr_ok` arrives in the same cycle, the FSM stays in IDLE.
  - Otherwise the payload and owner ID are latched and the FSM moves to HOLD.
- **HOLD**
  - The bus is driven from the latched payload. `data_req` stays at 1 even if the original requester deasserts.
  - On `data_addr_ok`, the FSM returns to IDLE. The next request cannot issue until the following cycle.
- **Requester accept signals**
  - `pipe_addr_ok` / `sb_addr_ok` equal `data_addr_ok` gated by the current owner.
  - In HOLD, a pipe owner killed by flush gets no `pipe_addr_ok`.
- **In-flight FIFO**
  - Each entry is {id, killed}.
  - Push on every bus accept (`data_req & data_addr_ok`); pop on `data_data_ok`.
  - Push and pop in the same cycle leave the count unchanged.
- **Full condition:** while count == OUTSTANDING, `data_req` = 0 and the FSM does not advance. A pop in the same cycle does not free a slot until the next cycle.
- **Response routing**
  - Responses are strictly in order; routing uses the head entry.
  - Head id=pipe, not killed: `pipe_data_ok` = 1 and `pipe_rdata` = `data_rdata`.
  - Head id=sb: `sb_data_ok` = 1.
  - Head killed: neither data_ok asserts.
- **Flush**
  - Sets `killed` on all pipe entries in the FIFO, including the entry pushed in the same cycle.
  - Marks a latched pipe payload in HOLD as killed. That payload is still issued (bus protocol requires it) and is pushed with killed=1.
  - Store-buffer entries are never killed.
  - In IDLE, pipe is not granted in the flush cycle.
- **busy** = (state == HOLD) | (count != 0).
- **Error case:** `data_data_ok` with an empty FIFO is a protocol error. It is ignored, and an assertion fires in simulation.

## Timing
- **Reset:** all outputs 0, FSM in IDLE, count 0, FIFO pointers 0.
  - Reset mid-transaction abandons all in-flight state.
  - The bus bridge is reset in the same cycle.
- **Request path:** pipe/sb request to `data_req` is 0 cycles (combinational) in IDLE.
- **Response path:** `data_data_ok` to the requester data_ok is 0 cycles, combinational from the head entry.
- FIFO flags and pointers update on the clk edge.
- **Back-to-back:** one accept per cycle is sustained while count < OUTSTANDING.
- **Pointer wrap:** pointers wrap modulo OUTSTANDING. Full/empty are derived from a count of width $clog2(OUTSTANDING)+1.

## Structure
- **Shared package entries:**
  - Size encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - Owner ID constants ID_PIPE=0 and ID_SB=1.
  - Grant FSM state encodings.
- **Sub-module `dbus_inflight_fifo`:**
  - OUTSTANDING-deep {id, killed} queue.
  - push/pop/flush_kill ports; head and count outputs.

## Test plan
- **Single pipe load:** pipe_req with addr 0x1000, word size; `data_addr_ok` in the same cycle; `data_data_ok` 3 cycles later with rdata 0xDEADBEEF → `pipe_addr_ok` in cycle 0; `pipe_data_ok` with 0xDEADBEEF in cycle 3; busy returns to 0 afterwards.
- **Simultaneous requests:** sb_req and pipe_req in the same cycle, `data_addr_ok` tied to 1 → sb issues first and pipe the next cycle; responses route to sb then pipe.
- **HOLD under flush:** pipe_req, `data_addr_ok` low for 3 cycles, flush in cycle 1, pipe_req dropped in cycle 2 → `data_req` held with the original address until accept; no `pipe_addr_ok`; no `pipe_data_ok` on the response.
- **Full:** OUTSTANDING=2, two accepts without responses → a third request sees `data_req`=0. After one `data_data_ok`, the third issues the next cycle.
- **Flush with mixed FIFO:** FIFO holds [pipe, sb] when flush asserts → the first response is absorbed; the second yields `sb_data_ok`.
- **Reset:** rst=0 while in HOLD with count=2 → the next cycle has all outputs 0 and busy=0.

Source files
------------

// File: rtl/dbus_arbiter_pkg.sv
// dbus_arbiter_pkg: shared encodings for the data-bus arbiter
// Provides size codes, owner ids, grant FSM states and the in-flight entry type.
package dbus_arbiter_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic ID_PIPE = 1'b0;
  localparam logic ID_SB = 1'b1;
  typedef enum logic {IDLE, HOLD} state_t;
  typedef struct packed {
    logic id;
    logic killed;
  } entry_t;
endpackage

// File: rtl/dbus_inflight_fifo.sv
// dbus_inflight_fifo: in-order queue of {id, killed} for accepted bus transactions
// Ports: clk, rst (sync, active-low); push/push_entry on bus accept; pop on response;
// flush_kill marks every pipe entry (stored or being pushed) killed; head/count out.
module dbus_inflight_fifo
  import dbus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  input  logic                   flush_kill,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic pop_ok;
  // a response with nothing in flight is a bus protocol error and is dropped
  assign pop_ok = pop & (count != '0);
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (flush_kill && mem[i].id == ID_PIPE) mem[i].killed <= 1'b1;
      if (push) begin
        mem[wp] <= '{id: push_entry.id, killed: push_entry.killed | (flush_kill & (push_entry.id == ID_PIPE))};
        wp <= wp + PW'(1);
      end
      if (pop_ok) rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clk) if (rst && pop) assert (count != '0);
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the data bus between the pipeline and the store-buffer drain
// Ports: clk, rst (sync, active-low); pipe_* and sb_* requester sides; flush kills
// pipeline transactions; data_* bus side; busy when anything is latched or in flight.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_req,
  input  logic        pipe_wr,
  input  logic [1:0]  pipe_size,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  input  logic [3:0]  pipe_wstrb,
  output logic        pipe_addr_ok,
  output logic        pipe_data_ok,
  output logic [31:0] pipe_rdata,
  input  logic        sb_req,
  input  logic [1:0]  sb_size,
  input  logic [31:0] sb_addr,
  input  logic [3:0]  sb_wstrb,
  input  logic [31:0] sb_wdata,
  output logic        sb_addr_ok,
  output logic        sb_data_ok,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        busy
);
  localparam int CW = $clog2(OUTSTANDING) + 1;
  state_t state;
  logic hold, full, cur_id, cur_killed, accept, resp;
  logic h_wr, h_id, h_killed;
  logic [1:0] h_size, i_size;
  logic [31:0] h_addr, h_wdata, i_addr, i_wdata;
  logic [3:0] h_wstrb, i_wstrb;
  logic i_wr;
  logic [CW-1:0] count;
  entry_t head, push_entry;
  always_comb begin
    hold = state == HOLD;
    // a pop this cycle does not free a slot until the count register updates
    full = count == CW'(OUTSTANDING);
    // store buffer wins so older uncached stores reach the bus before younger loads
    data_req = rst & ~full & (hold | sb_req | (pipe_req & ~flush));
    i_wr = sb_req | pipe_wr;
    i_size = sb_req ? sb_size : pipe_size;
    i_addr = sb_req ? sb_addr : pipe_addr;
    i_wstrb = sb_req ? sb_wstrb : pipe_wstrb;
    i_wdata = sb_req ? sb_wdata : pipe_wdata;
    cur_id = hold ? h_id : (sb_req ? ID_SB : ID_PIPE);
    // a held pipe payload is still issued after a flush, but as a killed entry
    cur_killed = hold & (h_killed | (flush & (h_id == ID_PIPE)));
    accept = data_req & data_addr_ok;
    push_entry = '{id: cur_id, killed: cur_killed};
    data_wr = data_req & (hold ? h_wr : i_wr);
    data_size = data_req ? (hold ? h_size : i_size) : '0;
    data_addr = data_req ? (hold ? h_addr : i_addr) : '0;
    data_wstrb = data_req ? (hold ? h_wstrb : i_wstrb) : '0;
    data_wdata = data_req ? (hold ? h_wdata : i_wdata) : '0;
    pipe_addr_ok = accept & (cur_id == ID_PIPE) & ~cur_killed;
    sb_addr_ok = accept & (cur_id == ID_SB);
    resp = rst & data_data_ok & (count != '0);
    pipe_data_ok = resp & (head.id == ID_PIPE) & ~head.killed;
    sb_data_ok = resp & (head.id == ID_SB);
    pipe_rdata = pipe_data_ok ? data_rdata : '0;
    busy = hold | (count != '0);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      h_wr <= 1'b0;
      h_id <= 1'b0;
      h_killed <= 1'b0;
      h_size <= '0;
      h_addr <= '0;
      h_wstrb <= '0;
      h_wdata <= '0;
    end else if (!hold) begin
      if (data_req && !data_addr_ok) begin
        state <= HOLD;
        h_wr <= i_wr;
        h_id <= cur_id;
        h_killed <= 1'b0;
        h_size <= i_size;
        h_addr <= i_addr;
        h_wstrb <= i_wstrb;
        h_wdata <= i_wdata;
      end
    end else begin
      h_killed <= cur_killed;
      if (accept) state <= IDLE;
    end
  end
  dbus_inflight_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .push_entry(push_entry),
    .pop(data_data_ok),
    .flush_kill(flush),
    .head(head),
    .count(count)
  );
endmodule
